// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch target buffer with saturating direction
//               counters, same-cycle fetch prediction, EX-stage resolution
//               updates, misprediction flag and saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic              up_taken,
    input  logic [ADDR_W-1:0] up_target,
    input  logic              up_pred_taken,
    input  logic [ADDR_W-1:0] up_pred_target,
    input  logic              inv_all,
    output logic              up_mispredict,
    output logic [ADDR_W-1:0] up_redirect,
    output logic [15:0]       branch_cnt,
    output logic [15:0]       mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [CTR_W-1:0] c_ctr_max = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ctr_wt  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [15:0]      c_cnt_max = 16'hFFFF;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];

    logic [15:0] r_branch_cnt;
    logic [15:0] r_mispred_cnt;

    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;
    logic              w_up_hit;
    logic [CTR_W-1:0]  w_up_ctr;
    logic [CTR_W-1:0]  w_ctr_next;

    // ------------------------------------------------------------------
    // Lookup: reads only registered state, so same-cycle updates are not
    // visible until the following cycle.
    // ------------------------------------------------------------------
    assign w_lk_idx  = lk_pc[IDX_W-1:0];
    assign w_lk_tag  = lk_pc[ADDR_W-1:IDX_W];
    assign lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign lk_taken  = lk_hit && r_ctr[w_lk_idx][CTR_W-1];
    assign lk_target = lk_taken ? r_target[w_lk_idx] : lk_pc + ADDR_W'(1);

    // ------------------------------------------------------------------
    // Resolution
    // ------------------------------------------------------------------
    assign up_mispredict = up_valid &&
                           ((up_taken != up_pred_taken) ||
                            (up_taken && (up_target != up_pred_target)));
    assign up_redirect   = up_taken ? up_target : up_pc + ADDR_W'(1);

    assign w_up_idx = up_pc[IDX_W-1:0];
    assign w_up_tag = up_pc[ADDR_W-1:IDX_W];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = r_ctr[w_up_idx];

    always_comb begin
        w_ctr_next = w_up_ctr;
        if (up_taken) begin
            if (w_up_ctr != c_ctr_max) begin
                w_ctr_next = w_up_ctr + CTR_W'(1);
            end
        end else if (w_up_ctr != '0) begin
            w_ctr_next = w_up_ctr - CTR_W'(1);
        end
    end

    // Invalidate wins over a coincident update; tag/target/ctr are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (inv_all) begin
            r_valid <= '0;
        end else if (up_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_ctr_next;
                if (up_taken) begin
                    r_target[w_up_idx] <= up_target;
                end
            end else if (up_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= up_target;
                r_ctr[w_up_idx]    <= c_ctr_wt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters, saturating, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (up_valid && (r_branch_cnt != c_cnt_max)) begin
                r_branch_cnt <= r_branch_cnt + 16'd1;
            end
            if (up_mispredict && (r_mispred_cnt != c_cnt_max)) begin
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
